// File: rtl/core_loader.sv
// core_loader: streams len words from the activation/weight SRAMs into L0 and/or IFIFO.
// Latency: first SRAM read 1 cycle after start, first write 2 cycles after, done at start+len+2 unstalled.
// Backpressure: a full destination stops new issues; a word already in flight is parked in a 1-entry hold.
//
// Ports:
//   clk, reset (async, active-low)           clocking / reset
//   start, mode, data_mode, base_*, len      transfer request, latched when start is accepted in IDLE
//   busy, done                               status: busy through RUN and DONE, done is a 1-cycle pulse
//   act_cen/act_a/act_q, wt_cen/wt_a/wt_q    SRAM read ports (cen active-low, q valid one cycle after cen=0)
//   l0_wr/l0_in/l0_full                      L0 write port (stream A)
//   ififo_wr/ififo_in/ififo_full             IFIFO write port (stream B, output-stationary only)
module core_loader #(
    parameter  int bw     = 4,
    parameter  int row    = 8,
    parameter  int addr_w = 11,
    localparam int W      = bw * row
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              data_mode,
    input  logic [addr_w-1:0] base_act,
    input  logic [addr_w-1:0] base_wt,
    input  logic [addr_w-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              act_cen,
    output logic [addr_w-1:0] act_a,
    input  logic [W-1:0]      act_q,
    output logic              wt_cen,
    output logic [addr_w-1:0] wt_a,
    input  logic [W-1:0]      wt_q,
    output logic              l0_wr,
    output logic [W-1:0]      l0_in,
    input  logic              l0_full,
    output logic              ififo_wr,
    output logic [W-1:0]      ififo_in,
    input  logic              ififo_full
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Transfer parameters captured at start.
    logic              r_mode;
    logic              r_dmode;
    logic [addr_w-1:0] r_base_act;
    logic [addr_w-1:0] r_base_wt;
    logic [addr_w-1:0] r_len;
    logic [addr_w-1:0] r_iss_cnt;
    logic [addr_w-1:0] r_wr_cnt;

    // Stream A feeds L0, stream B feeds IFIFO.
    logic              r_a_pend;      // read issued last cycle, q arrives now
    logic              r_b_pend;
    logic              r_a_hold_vld;
    logic              r_b_hold_vld;
    logic [W-1:0]      r_a_hold_dat;
    logic [W-1:0]      r_b_hold_dat;
    // Set when one stream has written the current word but the other has not yet.
    logic              r_a_fin;
    logic              r_b_fin;

    logic              w_accept;
    logic              w_os;
    logic              w_issue;
    logic [W-1:0]      w_a_q;
    logic              w_a_wr_dir;
    logic              w_a_wr_hold;
    logic              w_b_wr_dir;
    logic              w_b_wr_hold;
    logic              w_a_fin;
    logic              w_b_fin;
    logic              w_inc;
    logic [addr_w-1:0] w_wr_cnt_nxt;
    logic              w_holds_nxt;

    assign w_os  = ~r_mode;
    // Stream A reads the weight SRAM only in WS mode with data_mode=1.
    assign w_a_q = (r_mode && r_dmode) ? wt_q : act_q;

    // A word is only issued when every active stream could accept its return
    // directly; this keeps the hold drain and a fresh return from colliding.
    assign w_issue = (r_state == S_RUN) && (r_iss_cnt < r_len)
                   && !l0_full && !r_a_hold_vld
                   && (!w_os || (!ififo_full && !r_b_hold_vld));

    assign w_a_wr_hold = r_a_hold_vld & ~l0_full;
    assign w_a_wr_dir  = r_a_pend & ~l0_full;
    assign w_b_wr_hold = r_b_hold_vld & ~ififo_full;
    assign w_b_wr_dir  = r_b_pend & ~ififo_full;

    // A word counts as written once every active stream has delivered it;
    // in OS mode the two streams can finish in different cycles.
    assign w_a_fin      = r_a_fin | w_a_wr_hold | w_a_wr_dir;
    assign w_b_fin      = r_b_fin | w_b_wr_hold | w_b_wr_dir;
    assign w_inc        = w_a_fin & (w_b_fin | ~w_os);
    assign w_wr_cnt_nxt = r_wr_cnt + {{(addr_w-1){1'b0}}, w_inc};
    assign w_holds_nxt  = ((r_a_pend | r_a_hold_vld) & l0_full)
                        | ((r_b_pend | r_b_hold_vld) & ififo_full);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_dmode      <= 1'b0;
            r_base_act   <= '0;
            r_base_wt    <= '0;
            r_len        <= '0;
            r_iss_cnt    <= '0;
            r_wr_cnt     <= '0;
            r_a_pend     <= 1'b0;
            r_b_pend     <= 1'b0;
            r_a_hold_vld <= 1'b0;
            r_b_hold_vld <= 1'b0;
            r_a_hold_dat <= '0;
            r_b_hold_dat <= '0;
            r_a_fin      <= 1'b0;
            r_b_fin      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mode     <= mode;
                r_dmode    <= data_mode;
                r_base_act <= base_act;
                r_base_wt  <= base_wt;
                r_len      <= len;
                r_iss_cnt  <= '0;
                r_wr_cnt   <= '0;
            end else begin
                if (w_issue) begin
                    r_iss_cnt <= r_iss_cnt + 1'b1;
                end
                r_wr_cnt <= w_wr_cnt_nxt;
            end
            r_a_pend <= w_issue;
            r_b_pend <= w_issue & w_os;

            if (r_a_pend && l0_full) begin
                r_a_hold_vld <= 1'b1;
                r_a_hold_dat <= w_a_q;
            end else if (w_a_wr_hold) begin
                r_a_hold_vld <= 1'b0;
            end

            if (r_b_pend && ififo_full) begin
                r_b_hold_vld <= 1'b1;
                r_b_hold_dat <= wt_q;
            end else if (w_b_wr_hold) begin
                r_b_hold_vld <= 1'b0;
            end

            r_a_fin <= w_a_fin & ~w_inc;
            r_b_fin <= w_b_fin & ~w_inc;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        act_cen     = 1'b1;
        wt_cen      = 1'b1;
        act_a       = '0;
        wt_a        = '0;
        l0_wr       = 1'b0;
        l0_in       = '0;
        ififo_wr    = 1'b0;
        ififo_in    = '0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if ((w_wr_cnt_nxt == r_len) && !w_holds_nxt) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_issue && (w_os || !r_dmode)) begin
            act_cen = 1'b0;
            act_a   = r_base_act + r_iss_cnt;
        end
        if (w_issue && (w_os || r_dmode)) begin
            wt_cen = 1'b0;
            wt_a   = r_base_wt + r_iss_cnt;
        end

        // Held data goes first; the issue rule keeps it from meeting a return.
        if (w_a_wr_hold) begin
            l0_wr = 1'b1;
            l0_in = r_a_hold_dat;
        end else if (w_a_wr_dir) begin
            l0_wr = 1'b1;
            l0_in = w_a_q;
        end
        if (w_b_wr_hold) begin
            ififo_wr = 1'b1;
            ififo_in = r_b_hold_dat;
        end else if (w_b_wr_dir) begin
            ififo_wr = 1'b1;
            ififo_in = wt_q;
        end
    end

endmodule

// File: tb/tb_core_loader.sv
// tb_core_loader: directed bench for core_loader with a queue-based reference of
// the words and addresses each transfer must produce, checked every cycle.
module tb_core_loader;
    localparam int AW = 11;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          reset, start, mode, data_mode;
    logic [AW-1:0] base_act, base_wt, len;
    logic          busy, done, act_cen, wt_cen, l0_wr, ififo_wr;
    logic [AW-1:0] act_a, wt_a;
    logic [W-1:0]  act_q = '0, wt_q = '0, l0_in, ififo_in;
    logic          l0_full, ififo_full;

    always #5 clk = ~clk;

    core_loader #(.bw(4), .row(8), .addr_w(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .data_mode(data_mode),
        .base_act(base_act), .base_wt(base_wt), .len(len), .busy(busy), .done(done),
        .act_cen(act_cen), .act_a(act_a), .act_q(act_q),
        .wt_cen(wt_cen), .wt_a(wt_a), .wt_q(wt_q),
        .l0_wr(l0_wr), .l0_in(l0_in), .l0_full(l0_full),
        .ififo_wr(ififo_wr), .ififo_in(ififo_in), .ififo_full(ififo_full)
    );

    // SRAM contents: tag in the top byte, address in the low bits.
    function automatic logic [W-1:0] act_word(input logic [AW-1:0] a);
        return 32'hAC00_0000 | {21'b0, a};
    endfunction
    function automatic logic [W-1:0] wt_word(input logic [AW-1:0] a);
        return 32'hEE00_0000 | {21'b0, a};
    endfunction

    always @(posedge clk) if (!act_cen) act_q <= act_word(act_a);
    always @(posedge clk) if (!wt_cen)  wt_q  <= wt_word(wt_a);

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vec = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference of what the running transfer still owes.
    logic [AW-1:0] exp_act_a[$], exp_wt_a[$];
    logic [W-1:0]  exp_l0[$], exp_if[$];
    logic          m_active = 1'b0, m_mode = 1'b0, m_dmode = 1'b0;

    // Observation logs for the directed checks.
    logic [W-1:0]  l0_log[$];
    int            l0_cyc[$];
    logic [AW-1:0] wt_a_log[$];
    int            wt_rd_cyc[$];
    int            act_rd_cnt, if_cnt, busy_cnt, done_cyc, s_cyc;
    logic          done_seen = 1'b0, prev_done = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            if (!act_cen) begin
                act_rd_cnt++;
                if (exp_act_a.size() == 0) chk("act_unexpected_rd", 1, 0);
                else chk("act_a", act_a, exp_act_a.pop_front());
            end
            if (!wt_cen) begin
                wt_a_log.push_back(wt_a);
                wt_rd_cyc.push_back(cyc);
                if (exp_wt_a.size() == 0) chk("wt_unexpected_rd", 1, 0);
                else chk("wt_a", wt_a, exp_wt_a.pop_front());
            end
            if (l0_wr) begin
                chk("l0_wr_while_full", l0_full, 0);
                l0_log.push_back(l0_in);
                l0_cyc.push_back(cyc);
                if (exp_l0.size() == 0) chk("l0_unexpected_wr", 1, 0);
                else chk("l0_in", l0_in, exp_l0.pop_front());
            end
            if (ififo_wr) begin
                chk("ififo_wr_while_full", ififo_full, 0);
                if_cnt++;
                if (exp_if.size() == 0) chk("ififo_unexpected_wr", 1, 0);
                else chk("ififo_in", ififo_in, exp_if.pop_front());
            end
            if (m_active && m_mode) begin
                chk("ws_ififo_idle", ififo_wr, 0);
                chk("ws_unused_cen", m_dmode ? act_cen : wt_cen, 1);
            end
            if (!busy) chk("idle_quiet", {act_cen, wt_cen, l0_wr, ififo_wr}, 4'b1100);
            if (busy) busy_cnt++;
            if (done) begin
                chk("done_single_cycle", prev_done, 0);
                chk("done_all_written",
                    exp_l0.size() + exp_if.size() + exp_act_a.size() + exp_wt_a.size(), 0);
                done_seen = 1'b1;
                done_cyc  = cyc;
                m_active  = 1'b0;
            end
            prev_done = done;
        end
    end

    task automatic clear_logs();
        l0_log.delete(); l0_cyc.delete(); wt_a_log.delete(); wt_rd_cyc.delete();
        act_rd_cnt = 0; if_cnt = 0; busy_cnt = 0;
    endtask

    task automatic launch(input logic m, input logic dm, input logic [AW-1:0] ba,
                          input logic [AW-1:0] bwt, input logic [AW-1:0] ln);
        @(negedge clk);
        mode = m; data_mode = dm; base_act = ba; base_wt = bwt; len = ln; start = 1'b1;
        s_cyc = cyc; done_seen = 1'b0;
        m_active = 1'b1; m_mode = m; m_dmode = dm;
        for (int k = 0; k < int'(ln); k++) begin
            if (!m) begin
                exp_act_a.push_back(ba + AW'(k));
                exp_l0.push_back(act_word(ba + AW'(k)));
                exp_wt_a.push_back(bwt + AW'(k));
                exp_if.push_back(wt_word(bwt + AW'(k)));
            end else if (dm) begin
                exp_wt_a.push_back(bwt + AW'(k));
                exp_l0.push_back(wt_word(bwt + AW'(k)));
            end else begin
                exp_act_a.push_back(ba + AW'(k));
                exp_l0.push_back(act_word(ba + AW'(k)));
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!done_seen && n < maxc) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!done_seen) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_act_cen", act_cen, 1);
        chk("rst_wt_cen", wt_cen, 1);
        chk("rst_act_a", act_a, 0);
        chk("rst_wt_a", wt_a, 0);
        chk("rst_l0_wr", l0_wr, 0);
        chk("rst_ififo_wr", ififo_wr, 0);
        chk("rst_l0_in", l0_in, 0);
        chk("rst_ififo_in", ififo_in, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; mode = 1'b0; data_mode = 1'b0;
        base_act = '0; base_wt = '0; len = '0; l0_full = 1'b0; ififo_full = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals();
        @(negedge clk);
        reset = 1'b1;

        // WS from weight SRAM, no backpressure.
        clear_logs();
        launch(1'b1, 1'b1, 11'd0, 11'd5, 11'd4);
        wait_done(50);
        chk("t1_done_lat", done_cyc - s_cyc, 6);
        chk("t1_rd_cnt", wt_a_log.size(), 4);
        chk("t1_wt_a0", wt_a_log[0], 5);
        chk("t1_wt_a3", wt_a_log[3], 8);
        chk("t1_rd_first", wt_rd_cyc[0] - s_cyc, 1);
        chk("t1_rd_last", wt_rd_cyc[3] - s_cyc, 4);
        chk("t1_l0_first", l0_log[0], 32'hEE00_0005);
        chk("t1_l0_last", l0_log[3], 32'hEE00_0008);
        chk("t1_wr_first", l0_cyc[0] - s_cyc, 2);
        chk("t1_wr_last", l0_cyc[3] - s_cyc, 5);
        chk("t1_act_rd", act_rd_cnt, 0);
        chk("t1_if_cnt", if_cnt, 0);
        chk("t1_busy_cycles", busy_cnt, 6);

        // OS lockstep, L0 full for 3 cycles mid-stream.
        clear_logs();
        launch(1'b0, 1'b0, 11'd0, 11'd100, 11'd8);
        @(negedge clk);
        @(negedge clk);
        l0_full = 1'b1;
        repeat (3) @(negedge clk);
        l0_full = 1'b0;
        wait_done(100);
        chk("t2_l0_cnt", l0_log.size(), 8);
        chk("t2_if_cnt", if_cnt, 8);
        chk("t2_act_rd", act_rd_cnt, 8);
        chk("t2_wt_rd", wt_a_log.size(), 8);
        chk("t2_l0_last", l0_log[7], 32'hAC00_0007);
        chk("t2_done_lat", done_cyc - s_cyc, 14);

        // WS from activation SRAM; full rises as word 0 returns.
        clear_logs();
        launch(1'b1, 1'b0, 11'd8, 11'd0, 11'd3);
        @(negedge clk);
        l0_full = 1'b1;
        repeat (2) @(negedge clk);
        l0_full = 1'b0;
        wait_done(50);
        chk("t3_wr_first", l0_cyc[0] - s_cyc, 4);
        chk("t3_l0_0", l0_log[0], 32'hAC00_0008);
        chk("t3_l0_2", l0_log[2], 32'hAC00_000A);
        chk("t3_l0_cnt", l0_log.size(), 3);
        chk("t3_act_rd", act_rd_cnt, 3);
        chk("t3_wt_rd", wt_a_log.size(), 0);
        chk("t3_done_lat", done_cyc - s_cyc, 8);

        // Zero-length transfer.
        clear_logs();
        launch(1'b1, 1'b1, 11'd0, 11'd0, 11'd0);
        wait_done(10);
        chk("t4_done_lat", done_cyc - s_cyc, 1);
        chk("t4_busy_cycles", busy_cnt, 1);
        chk("t4_reads", act_rd_cnt + wt_a_log.size(), 0);
        chk("t4_writes", l0_log.size() + if_cnt, 0);

        // Reset in the middle of an OS transfer, then a short clean one.
        clear_logs();
        launch(1'b0, 1'b0, 11'd0, 11'd0, 11'd16);
        n = 0;
        while (l0_log.size() < 5 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("t5_reached_5_writes", l0_log.size(), 5);
        reset = 1'b0;
        exp_act_a.delete(); exp_wt_a.delete(); exp_l0.delete(); exp_if.delete();
        m_active = 1'b0;
        #1;
        chk_reset_vals();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_logs();
        launch(1'b0, 1'b0, 11'd20, 11'd40, 11'd2);
        wait_done(20);
        chk("t5_l0_cnt", l0_log.size(), 2);
        chk("t5_if_cnt", if_cnt, 2);
        chk("t5_l0_1", l0_log[1], 32'hAC00_0015);
        chk("t5_done_lat", done_cyc - s_cyc, 4);

        // Start while busy is ignored; weight address wraps.
        clear_logs();
        launch(1'b1, 1'b1, 11'd0, 11'd2046, 11'd4);
        start = 1'b1; base_wt = 11'd500; len = 11'd9; data_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(50);
        chk("t6_rd_cnt", wt_a_log.size(), 4);
        chk("t6_wt_a0", wt_a_log[0], 2046);
        chk("t6_wt_a1", wt_a_log[1], 2047);
        chk("t6_wt_a2", wt_a_log[2], 0);
        chk("t6_wt_a3", wt_a_log[3], 1);
        chk("t6_l0_cnt", l0_log.size(), 4);
        chk("t6_l0_2", l0_log[2], 32'hEE00_0000);
        chk("t6_act_rd", act_rd_cnt, 0);
        chk("t6_done_lat", done_cyc - s_cyc, 6);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/core_loader.md
# core_loader

Parametrised SRAM-to-corelet transfer engine that succeeds the fixed mode mux between the activation/weight SRAMs and the corelet inputs. On a start pulse it streams a programmable number of words from the activation and/or weight SRAM into L0 and/or IFIFO at one word per cycle. It honours full backpressure without losing data. It supports weight-stationary and output-stationary modes, and signals completion.

## Interface
- bw, 4, bits per element
- row, 8, elements per word; word width W = bw*row
- addr_w, 11, SRAM address / length width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  one-cycle request; accepted only when idle
- mode  in  1  1 = weight stationary (WS), 0 = output stationary (OS); latched at start
- data_mode  in  1  WS only: 1 = weight SRAM source, 0 = activation SRAM source; latched at start
- base_act  in  addr_w  first activation address; latched at start
- base_wt  in  addr_w  first weight address; latched at start
- len  in  addr_w  number of words to move; latched at start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- act_cen  out  1  activation SRAM chip enable, active-low (read only)
- act_a  out  addr_w  activation SRAM address
- act_q  in  W  activation SRAM read data, valid the cycle after act_cen=0
- wt_cen, wt_a, wt_q: same as the act_* ports, for the weight SRAM
- l0_wr  out  1  L0 write strobe
- l0_in  out  W  L0 write data
- l0_full  in  1  L0 cannot accept a write
- ififo_wr  out  1  IFIFO write strobe
- ififo_in  out  W  IFIFO write data
- ififo_full  in  1  IFIFO cannot accept a write

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start (len != 0).
  - IDLE -> DONE on start with len == 0; no SRAM access occurs.
  - RUN -> DONE when wr_cnt == len and all hold registers are empty.
  - DONE -> IDLE unconditionally; done=1 only in DONE.
- Active streams depend on mode.
  - OS mode: activation -> L0 and weight -> IFIFO run in lockstep. Word k reads base_act+k and base_wt+k.
  - WS mode: one stream into L0. The source is the weight SRAM at base_wt+k if data_mode=1, else the activation SRAM at base_act+k. IFIFO and the unused SRAM stay idle (cen=1, wr=0).
- Issue rule, evaluated each RUN cycle: issue word iss_cnt when iss_cnt < len and, for every active stream, dest full=0 and hold empty. Issue drives cen=0 and the address, and increments iss_cnt.
- Return handling, per stream, the cycle after issue:
  - If full=0: write directly (wr=1, in=q).
  - Otherwise: capture q into a 1-entry hold register.
- Hold drain: when the hold is valid and full=0, write the held data and clear the hold. Hold writes have priority. The issue rule guarantees a return and a hold write never coincide on one stream.
- wr_cnt increments when the last active stream finishes writing word k. In OS mode the two streams may complete in different cycles.
- busy=1 in RUN and DONE.
- start is ignored while not IDLE.
- Counters are addr_w wide. Addresses wrap modulo 2^addr_w.
- Reset (any time, including mid-transfer): go to IDLE, clear counters and holds, drop in-flight data.

## Timing
- Reset values: busy=0, done=0, act_cen=1, wt_cen=1, act_a=0, wt_a=0, l0_wr=0, ififo_wr=0, l0_in=0, ififo_in=0.
- First SRAM read occurs the cycle after start is sampled.
- First write occurs 2 cycles after start.
- With no backpressure, one word per cycle. The last write is at cycle start+len+1 and done is at start+len+2.
- Each full cycle on a blocking stream adds at least one cycle. No word is dropped or duplicated.
- wr strobes are single-cycle per word. Data is stable in the same cycle as its strobe.

## Test plan
- WS, data_mode=1, base_wt=5, len=4, fulls=0 -> wt_a=5,6,7,8 on consecutive cycles; l0_wr 4 consecutive cycles carrying SRAM[5..8]; done at start+6; act_cen stays 1; ififo_wr stays 0.
- OS, base_act=0, base_wt=100, len=8, l0_full pulsed high 3 cycles mid-stream -> L0 receives act[0..7] in order and IFIFO receives wt[100..107] in order, exactly 8 writes each; issue stalls while full; done is asserted after the 8th pair.
- full rises the same cycle data returns (WS, len=3, full high 2 cycles) -> word captured in the hold and written the first cycle full=0; order preserved; no extra SRAM reads.
- len=0 start -> no cen=0; busy high 1 cycle; done pulse the cycle after start.
- reset=0 mid-transfer (OS, len=16, after 5 writes) -> all outputs return to their reset values immediately. A new start with len=2 completes cleanly with only 2 writes per stream.
- start asserted while busy, and base_wt=2046 with len=4 -> second start ignored; addresses 2046, 2047, 0, 1.
